// File: rtl/comb_equiv_sweeper_pkg.sv
// Shared definitions for the combinational equivalence sweeper:
// FSM state encoding and the binary-to-Gray helper.
package comb_equiv_sweeper_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int unsigned MAXW = 16;

    function automatic logic [MAXW-1:0] bin2gray(input logic [MAXW-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/comb_equiv_sweeper_cmp_core.sv
// Combinational compare of all channels against channel 0: per-channel
// difference vector plus a single any-mismatch flag.
module sweep_cmp_core #(
    parameter int unsigned CHANNELS = 4
) (
    input  logic [CHANNELS-1:0] resp,
    output logic [CHANNELS-1:0] diff,
    output logic                mismatch
);

    assign diff     = resp ^ {CHANNELS{resp[0]}};
    assign mismatch = |diff;

endmodule

// File: rtl/comb_equiv_sweeper.sv
// Clocked exhaustive stimulus sweep over WIDTH inputs, comparing CHANNELS
// DUT responses against channel 0 and reporting error count and first failure.
module comb_equiv_sweeper
    import comb_equiv_sweeper_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned HOLD     = 2,
    parameter int unsigned GRAY     = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [WIDTH-1:0]    vec,
    input  logic [CHANNELS-1:0] resp,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [WIDTH:0]      err_count,
    output logic [WIDTH-1:0]    first_fail_vec,
    output logic [CHANNELS-1:0] fail_mask
);

    localparam int unsigned HCW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int unsigned CW  = WIDTH + 1;
    localparam logic [WIDTH-1:0] LAST_IDX = '1;

    function automatic logic [WIDTH-1:0] map_vec(input logic [WIDTH-1:0] i);
        return (GRAY != 0) ? WIDTH'(bin2gray(MAXW'(i))) : i;
    endfunction

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     idx;
    logic [HCW-1:0]       hcnt;
    logic [CHANNELS-1:0]  diff;
    logic                 mismatch;
    logic                 sample;
    logic                 last_sample;
    logic                 launch;

    sweep_cmp_core #(.CHANNELS(CHANNELS)) u_cmp (
        .resp     (resp),
        .diff     (diff),
        .mismatch (mismatch)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        sample      = (state == S_RUN) && (hcnt == HCW'(HOLD - 1));
        last_sample = sample && (idx == LAST_IDX);
        launch      = start && ((state == S_IDLE) || (state == S_DONE));
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_RUN;
            S_RUN:          if (last_sample) state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    // Results are cleared on the launch edge so a restart from DONE is fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx            <= '0;
            hcnt           <= '0;
            vec            <= '0;
            err_count      <= '0;
            first_fail_vec <= '0;
            fail_mask      <= '0;
        end else if (launch) begin
            idx            <= '0;
            hcnt           <= '0;
            vec            <= map_vec('0);
            err_count      <= '0;
            first_fail_vec <= '0;
            fail_mask      <= '0;
        end else if (state == S_RUN) begin
            if (sample) begin
                hcnt <= '0;
                if (mismatch) begin
                    err_count <= err_count + CW'(1);
                    if (err_count == '0) first_fail_vec <= vec;
                end
                fail_mask <= fail_mask | diff;
                if (!last_sample) begin
                    idx <= idx + WIDTH'(1);
                    vec <= map_vec(idx + WIDTH'(1));
                end
            end else begin
                hcnt <= hcnt + HCW'(1);
            end
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);
    assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_comb_equiv_sweeper.sv
// Self-checking bench for comb_equiv_sweeper: table-driven fault scenarios,
// randomized fault tables against a reference model, and reset/restart corners.
module tb_comb_equiv_sweeper;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, start_g = 1'b0;
    logic [3:0] vec, vec_g;
    logic [3:0] resp, resp_g;
    logic       busy, busy_g, done, done_g, pass, pass_g;
    logic [4:0] err_count, err_count_g;
    logic [3:0] ffv, ffv_g, mask, mask_g;

    int          mode = 0, mode_g = 0;
    logic [63:0] flips = '0;
    bit          sel = 1'b0;
    int          n_checks = 0, n_pass = 0;

    always #5 clk = ~clk;

    // Channel behaviour: 0 all equal, 1 ch2 inverted at vec 6,
    // 2 golden=A with ch1 stuck-0, 3 golden with random per-vector flips.
    function automatic logic [3:0] calc(input int m, input logic [3:0] v, input logic [63:0] fl);
        logic       g;
        logic [3:0] r;
        g = (v[0] & v[1]) | (v[2] ^ v[3]);
        r = {4{g}};
        case (m)
            1: if (v == 4'd6) r[2] = ~r[2];
            2: begin r = {4{v[0]}}; r[1] = 1'b0; end
            3: r = r ^ fl[v*4 +: 4];
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] ord(input int i, input bit gray);
        logic [3:0] b;
        b = i[3:0];
        return gray ? (b ^ (b >> 1)) : b;
    endfunction

    assign resp   = calc(mode,   vec,   flips);
    assign resp_g = calc(mode_g, vec_g, flips);

    comb_equiv_sweeper #(.WIDTH(4), .CHANNELS(4), .HOLD(2), .GRAY(0)) dut (
        .clk(clk), .rst(rst), .start(start), .vec(vec), .resp(resp),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail_vec(ffv), .fail_mask(mask)
    );

    comb_equiv_sweeper #(.WIDTH(4), .CHANNELS(4), .HOLD(2), .GRAY(1)) dut_g (
        .clk(clk), .rst(rst), .start(start_g), .vec(vec_g), .resp(resp_g),
        .busy(busy_g), .done(done_g), .pass(pass_g), .err_count(err_count_g),
        .first_fail_vec(ffv_g), .fail_mask(mask_g)
    );

    logic [3:0] s_vec, s_ffv, s_mask;
    logic       s_busy, s_done, s_pass;
    logic [4:0] s_err;
    assign s_vec  = sel ? vec_g : vec;
    assign s_ffv  = sel ? ffv_g : ffv;
    assign s_mask = sel ? mask_g : mask;
    assign s_busy = sel ? busy_g : busy;
    assign s_done = sel ? done_g : done;
    assign s_pass = sel ? pass_g : pass;
    assign s_err  = sel ? err_count_g : err_count;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive_start(input logic v);
        if (sel) start_g = v;
        else     start   = v;
    endtask

    // Reference: walk the sweep order, compare each channel to channel 0.
    task automatic model(input int m, input bit gray, output int err, output int ffv_e,
                         output int mask_e);
        logic [3:0] v, r;
        bit         any;
        err = 0; ffv_e = 0; mask_e = 0;
        for (int i = 0; i < 16; i++) begin
            v   = ord(i, gray);
            r   = calc(m, v, flips);
            any = 1'b0;
            for (int ch = 1; ch < 4; ch++) begin
                if (r[ch] != r[0]) begin
                    mask_e = mask_e | (1 << ch);
                    any    = 1'b1;
                end
            end
            if (any) begin
                if (err == 0) ffv_e = int'(v);
                err++;
            end
        end
    endtask

    // Starts a sweep and follows it to done; poke >= 0 pulses start mid-run.
    task automatic run_sweep(input int poke, output int cycles, output int vec_bad);
        int busy_bad;
        @(negedge clk);
        drive_start(1'b1);
        @(posedge clk); #1;
        drive_start(1'b0);
        check("clr_err", 64'(s_err), 64'd0);
        check("clr_done", 64'(s_done), 64'd0);
        cycles = 0; vec_bad = 0; busy_bad = 0;
        while (!s_done && cycles < 200) begin
            if (s_vec !== ord((cycles / 2 > 15) ? 15 : cycles / 2, sel)) vec_bad++;
            if (s_busy !== 1'b1) busy_bad++;
            if (cycles == poke) drive_start(1'b1);
            @(posedge clk); #1;
            drive_start(1'b0);
            cycles++;
        end
        check("busy_in_run", 64'(busy_bad), 64'd0);
        check("vec_at_done", 64'(s_vec), 64'(ord(15, sel)));
        check("busy_at_done", 64'(s_busy), 64'd0);
    endtask

    typedef struct {
        int mode;
        int err;
        int ffv;
        int mask;
        bit pass;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int cyc, vbad, e_err, e_ffv, e_mask;

        tbl[0] = '{mode: 0, err: 0, ffv: 0, mask: 4'b0000, pass: 1'b1};
        tbl[1] = '{mode: 1, err: 1, ffv: 6, mask: 4'b0100, pass: 1'b0};
        tbl[2] = '{mode: 2, err: 8, ffv: 1, mask: 4'b0010, pass: 1'b0};
        tbl[3] = '{mode: 0, err: 0, ffv: 0, mask: 4'b0000, pass: 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_vec", 64'(vec), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pass", 64'(pass), 64'd0);
        check("rst_err", 64'(err_count), 64'd0);
        check("rst_ffv", 64'(ffv), 64'd0);
        check("rst_mask", 64'(mask), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Entry 3 restarts from DONE after a failing run.
        sel = 1'b0;
        for (int t = 0; t < 4; t++) begin
            mode = tbl[t].mode;
            run_sweep(-1, cyc, vbad);
            check("tbl_cycles", 64'(cyc), 64'd32);
            check("tbl_vecseq", 64'(vbad), 64'd0);
            check("tbl_err", 64'(err_count), 64'(tbl[t].err));
            check("tbl_ffv", 64'(ffv), 64'(tbl[t].ffv));
            check("tbl_mask", 64'(mask), 64'(tbl[t].mask));
            check("tbl_pass", 64'(pass), 64'(tbl[t].pass));
        end

        // Results remain stable in DONE.
        repeat (5) @(posedge clk);
        #1;
        check("done_hold", 64'({done, pass, err_count}), 64'({1'b1, 1'b1, 5'd0}));

        for (int r = 0; r < 5; r++) begin
            sel   = (r == 4);
            flips = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            if (sel) mode_g = 3; else mode = 3;
            model(3, sel, e_err, e_ffv, e_mask);
            run_sweep(-1, cyc, vbad);
            check("rnd_cycles", 64'(cyc), 64'd32);
            check("rnd_err", 64'(s_err), 64'(e_err));
            check("rnd_ffv", 64'(s_ffv), 64'(e_ffv));
            check("rnd_mask", 64'(s_mask), 64'(e_mask));
            check("rnd_pass", 64'(s_pass), 64'(e_err == 0));
        end

        sel = 1'b1; mode_g = 0;
        run_sweep(-1, cyc, vbad);
        check("gray_cycles", 64'(cyc), 64'd32);
        check("gray_vecseq", 64'(vbad), 64'd0);
        check("gray_pass", 64'(pass_g), 64'd1);

        sel = 1'b0; mode = 0;
        run_sweep(10, cyc, vbad);
        check("poke_cycles", 64'(cyc), 64'd32);
        check("poke_vecseq", 64'(vbad), 64'd0);

        // Asynchronous reset mid-sweep.
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_vec", 64'(vec), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_err", 64'(err_count), 64'd0);
        check("arst_mask", 64'(mask), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_rst", 64'({busy, done, vec}), 64'd0);
        mode = 0;
        run_sweep(-1, cyc, vbad);
        check("rerun_cycles", 64'(cyc), 64'd32);
        check("rerun_vecseq", 64'(vbad), 64'd0);
        check("rerun_pass", 64'(pass), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
